// File: rtl/mod_add_sub_serial.sv
// Limb-serial modular adder/subtractor: (A + B) mod N or (A - B) mod N, LIMB_BITS per cycle.
// Optional `MOD_ADD_SUB_SERIAL_STATUS_EN adds the 'reduced' output (1 = corrected value U selected).
module mod_add_sub_serial #(
   parameter int NUM_OF_BITS = 256,
   parameter int LIMB_BITS   = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   op,
   input  logic [NUM_OF_BITS-1:0] A,
   input  logic [NUM_OF_BITS-1:0] B,
   input  logic [NUM_OF_BITS-1:0] N,
   output logic                   out_valid,
   input  logic                   out_ready,
`ifdef MOD_ADD_SUB_SERIAL_STATUS_EN
   output logic                   reduced,
`endif
   output logic [NUM_OF_BITS-1:0] out_result
);

   localparam int NUM_LIMBS = NUM_OF_BITS / LIMB_BITS;
   localparam int IDX_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t state, state_nxt;
   logic   accept, calc_en, last_limb;

   logic                   op_q;
   logic [NUM_OF_BITS-1:0] a_q, b_q, n_q;
   logic [NUM_OF_BITS-1:0] t_res, u_res;
   logic [IDX_W-1:0]       idx;
   logic                   c1_q, c2_q, sel_q;

   logic [LIMB_BITS-1:0]   a_l, b_l, n_l, t_l, u_l;
   logic [LIMB_BITS:0]     ch1, ch2;
   logic                   c1_n, c2_n, sel_n;

   // Top bit of the returned value is the carry-out.
   function automatic logic [LIMB_BITS:0] limb_add(input logic [LIMB_BITS-1:0] x,
                                                   input logic [LIMB_BITS-1:0] y,
                                                   input logic                 cin);
      return {1'b0, x} + {1'b0, y} + {{LIMB_BITS{1'b0}}, cin};
   endfunction

   // Top bit of the returned value is the borrow-out (two's complement underflow).
   function automatic logic [LIMB_BITS:0] limb_sub(input logic [LIMB_BITS-1:0] x,
                                                   input logic [LIMB_BITS-1:0] y,
                                                   input logic                 bin);
      return {1'b0, x} - {1'b0, y} - {{LIMB_BITS{1'b0}}, bin};
   endfunction

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign last_limb  = (idx == IDX_W'(NUM_LIMBS - 1));
   assign out_result = sel_q ? u_res : t_res;
`ifdef MOD_ADD_SUB_SERIAL_STATUS_EN
   assign reduced    = sel_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      calc_en   = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            calc_en = 1'b1;
            if (last_limb) state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Two chains per limb: chain1 forms T, chain2 forms the correction U from T.
   always_comb begin
      a_l  = a_q[idx*LIMB_BITS +: LIMB_BITS];
      b_l  = b_q[idx*LIMB_BITS +: LIMB_BITS];
      n_l  = n_q[idx*LIMB_BITS +: LIMB_BITS];
      ch1  = op_q ? limb_sub(a_l, b_l, c1_q) : limb_add(a_l, b_l, c1_q);
      t_l  = ch1[LIMB_BITS-1:0];
      c1_n = ch1[LIMB_BITS];
      ch2  = op_q ? limb_add(t_l, n_l, c2_q) : limb_sub(t_l, n_l, c2_q);
      u_l  = ch2[LIMB_BITS-1:0];
      c2_n = ch2[LIMB_BITS];
      // Add: U when the wide T >= N. Sub: U (T + N) when A < B.
      sel_n = op_q ? c1_n : (c1_n | ~c2_n);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q  <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         n_q   <= '0;
         t_res <= '0;
         u_res <= '0;
         idx   <= '0;
         c1_q  <= 1'b0;
         c2_q  <= 1'b0;
         sel_q <= 1'b0;
      end else if (accept) begin
         op_q <= op;
         a_q  <= A;
         b_q  <= B;
         n_q  <= N;
         idx  <= '0;
         c1_q <= 1'b0;
         c2_q <= 1'b0;
      end else if (calc_en) begin
         t_res[idx*LIMB_BITS +: LIMB_BITS] <= t_l;
         u_res[idx*LIMB_BITS +: LIMB_BITS] <= u_l;
         c1_q <= c1_n;
         c2_q <= c2_n;
         idx  <= idx + IDX_W'(1);
         if (last_limb) sel_q <= sel_n;
      end
   end

endmodule

// File: tb/tb_mod_add_sub_serial.sv
// Bench for mod_add_sub_serial (32-bit operands, 8-bit limbs, N = 0xFFFFFFFB): vector table,
// random modular checks, DONE back-pressure and mid-operation reset, with a result scoreboard.
`timescale 1ns/1ps
module tb_mod_add_sub_serial;
   localparam int          W    = 32;
   localparam int          LB   = 8;
   localparam logic [W-1:0] MODN = 32'hFFFFFFFB;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         op = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] A = '0, B = '0, N = MODN;
   logic         in_ready, out_valid;
   logic [W-1:0] out_result;
`ifdef MOD_ADD_SUB_SERIAL_STATUS_EN
   logic         reduced;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] res;
      logic         red;
   } exp_t;

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         red;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[12];

   mod_add_sub_serial #(.NUM_OF_BITS(W), .LIMB_BITS(LB)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .A         (A),
      .B         (B),
      .N         (N),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef MOD_ADD_SUB_SERIAL_STATUS_EN
      .reduced   (reduced),
`endif
      .out_result(out_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Scoreboard: pop one expectation per output handshake.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%h required=none", out_result);
         end else begin
            mon_e = sb.pop_front();
            chk("result", out_result, mon_e.res);
`ifdef MOD_ADD_SUB_SERIAL_STATUS_EN
            chk("reduced", 32'(reduced), 32'(mon_e.red));
`endif
         end
      end
   end

   task automatic wait_ready();
      int cyc = 0;
      while (!in_ready && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
   endtask

   // Returns cycles from accept edge until out_valid seen.
   task automatic wait_valid(output int cyc);
      cyc = 0;
      @(negedge clk);
      while (!out_valid && cyc < 20) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic red);
      int cyc;
      wait_ready();
      op = o; A = a; B = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Scramble inputs after accept; the operation in flight must not see them.
      A = $urandom; B = $urandom; op = ~o;
      sb.push_back('{res, red});
      wait_valid(cyc);
      chk("latency", 32'(cyc), 32'd4);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] ra, rb, rres, held;
      logic [W:0]   s;
      logic         rred;
      int           cyc;

      vecs[0]  = '{1'b0, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0};
      vecs[1]  = '{1'b0, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFF9, 1'b1};
      vecs[2]  = '{1'b0, 32'hFFFFFFFA, 32'h00000001, 32'h00000000, 1'b1};
      vecs[3]  = '{1'b1, 32'h00000002, 32'h00000005, 32'hFFFFFFF8, 1'b1};
      vecs[4]  = '{1'b1, 32'h00000005, 32'h00000002, 32'h00000003, 1'b0};
      vecs[5]  = '{1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
      vecs[6]  = '{1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0};
      vecs[7]  = '{1'b1, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b0};
      vecs[8]  = '{1'b1, 32'h00000000, 32'hFFFFFFFA, 32'h00000001, 1'b1};
      vecs[9]  = '{1'b0, 32'h7FFFFFFD, 32'h7FFFFFFD, 32'hFFFFFFFA, 1'b0};
      vecs[10] = '{1'b0, 32'h80000000, 32'h7FFFFFFB, 32'h00000000, 1'b1};
      vecs[11] = '{1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_result", out_result, 32'd0);
`ifdef MOD_ADD_SUB_SERIAL_STATUS_EN
      chk("rst_reduced", 32'(reduced), 32'd0);
`endif
      reset = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].red);

      for (int i = 0; i < 20; i++) begin
         ra = $urandom % MODN;
         rb = $urandom % MODN;
         if (i % 2 == 0) begin
            s    = {1'b0, ra} + {1'b0, rb};
            rred = (s >= {1'b0, MODN});
            rres = rred ? W'(s - {1'b0, MODN}) : s[W-1:0];
            run_op(1'b0, ra, rb, rres, rred);
         end else begin
            rred = (ra < rb);
            rres = rred ? (ra - rb + MODN) : (ra - rb);
            run_op(1'b1, ra, rb, rres, rred);
         end
      end

      // Back-pressure in DONE with a request pulsed meanwhile
      out_ready = 1'b0;
      wait_ready();
      op = 1'b0; A = 32'h12345678; B = 32'h0FEDCBA9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back('{32'h22222221, 1'b0});
      wait_valid(cyc);
      chk("hold_latency", 32'(cyc), 32'd4);
      held = out_result;
      chk("hold_value", held, 32'h22222221);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid = (i == 3 || i == 4);
         op = 1'b1; A = 32'h00000009; B = 32'h00000001;
         @(negedge clk);
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_out_result", out_result, held);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_hs_in_ready", 32'(in_ready), 32'd1);
      chk("post_hs_out_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_ghost_op", 32'(out_valid), 32'd0);
      end

      // Asynchronous reset during CALC limb 2
      @(posedge clk); #1;
      wait_ready();
      op = 1'b0; A = 32'h11111111; B = 32'h00000001; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_out_result", out_result, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_no_output", 32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
      run_op(1'b0, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0);

      repeat (3) @(posedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
